// File: rtl/sync_ram_arbiter_16x4.sv
// Round-robin access controller that lets two requesters share the
// single-port 16x4 synchronous RAM. After reset it can sweep the RAM with
// CLEAR_VAL before serving any request, then grants at most one access per
// cycle and alternates between the two sides under contention.
module sync_ram_arbiter_16x4 #(
  parameter logic [3:0] CLEAR_VAL      = 4'b0000,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [3:0] addr_a,
  input  logic [3:0] addr_b,
  input  logic [3:0] wdata_a,
  input  logic [3:0] wdata_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       rvalid_a,
  output logic       rvalid_b,
  output logic [3:0] rdata,
  output logic       busy,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic [3:0] ram_data,
  input  logic [3:0] ram_q
);

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] clr_addr_q, clr_addr_d;
  logic       prio_q, prio_d;
  logic       rvalid_a_q, rvalid_a_d;
  logic       rvalid_b_q, rvalid_b_d;

  // Grant decision: a lone requester always wins, a tie goes to prio_q
  // (0 = A, 1 = B); nothing is granted in reset or during the clear pass.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n && (state_q == SERVE)) begin
      if (req_a && (!req_b || !prio_q)) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  // RAM port steering: clear sweep, granted requester, or an idle read of A.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_a;
    ram_data = wdata_a;
    busy     = (state_q == CLEAR);
    if (!rst_n) begin
      busy = CLEAR_ON_RESET;
    end else if (state_q == CLEAR) begin
      ram_we   = 1'b1;
      ram_addr = clr_addr_q;
      ram_data = CLEAR_VAL;
    end else if (gnt_a) begin
      ram_we   = we_a;
      ram_addr = addr_a;
      ram_data = wdata_a;
    end else if (gnt_b) begin
      ram_we   = we_b;
      ram_addr = addr_b;
      ram_data = wdata_b;
    end
  end

  // Next-state logic: clear address sweep, priority hand-off and read valids.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    prio_d     = prio_q;
    rvalid_a_d = req_a & gnt_a & ~we_a;
    rvalid_b_d = req_b & gnt_b & ~we_b;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + 4'd1;
        if (clr_addr_q == 4'd15) begin
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (gnt_a) begin
          prio_d = 1'b1;
        end else if (gnt_b) begin
          prio_d = 1'b0;
        end
      end
      default: begin
        state_d = SERVE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : SERVE;
      clr_addr_q <= 4'd0;
      prio_q     <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      prio_q     <= prio_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  // A read whose response would land while reset is held is never delivered,
  // so the registered valids are suppressed as soon as rst_n drops.
  assign rvalid_a = rvalid_a_q & rst_n;
  assign rvalid_b = rvalid_b_q & rst_n;
  assign rdata    = ram_q;

endmodule

// File: tb/tb_sync_ram_arbiter_16x4.sv
// Self-checking bench for sync_ram_arbiter_16x4 with a behavioural 16x4 RAM.
// Read responses are predicted into a scoreboard queue when a read grant is
// expected and checked by a monitor when rvalid appears.
module tb_sync_ram_arbiter_16x4;

  localparam logic [3:0] CLEAR_VAL = 4'b0000;

  typedef struct {
    logic       side;
    logic [3:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [3:0] addr_a = '0, addr_b = '0, wdata_a = '0, wdata_b = '0;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_we;
  logic [3:0] rdata, ram_addr, ram_data;
  logic [3:0] ram_q = '0;
  logic       preload_req = 1'b0;

  logic [3:0] mem [16];
  logic [3:0] ref_mem [16];
  exp_t       sb [$];
  exp_t       mon_e;
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;

  sync_ram_arbiter_16x4 #(.CLEAR_VAL(CLEAR_VAL), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with one-cycle registered read and a
  // bench-controlled preload of nonzero values.
  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'((i % 15) + 1);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end
    ram_q <= mem[ram_addr];
  end

  // Response monitor: every rvalid must match the oldest predicted read.
  always @(negedge clk) begin
    if (rvalid_a || rvalid_b) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_rvalid: got rvalid_a=%0b rvalid_b=%0b, want none", rvalid_a, rvalid_b);
      end else begin
        mon_e = sb.pop_front();
        if (rvalid_a !== !mon_e.side || rvalid_b !== mon_e.side || rdata !== mon_e.data || cyc != mon_e.due) begin
          mismatched++;
          $display("[TB] FAIL read_response: got a=%0b b=%0b rdata=%h cyc=%0d, want a=%0b b=%0b rdata=%h cyc=%0d",
                   rvalid_a, rvalid_b, rdata, cyc, !mon_e.side, mon_e.side, mon_e.data, mon_e.due);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      compared++;
      mismatched++;
      mon_e = sb.pop_front();
      $display("[TB] FAIL missing_rvalid: got no rvalid at cyc=%0d, want side=%0b rdata=%h", cyc, mon_e.side, mon_e.data);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, want $finish before timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic push_exp(input logic side, input logic [3:0] data);
    exp_t e;
    e.side = side;
    e.data = data;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic drive_idle();
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    drive_idle();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_clear();
    repeat (16) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) ref_mem[i] = CLEAR_VAL;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    preload_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      compared++;
      if ({busy, ram_we, gnt_a, gnt_b, rvalid_a} !== 5'b10000) begin
        mismatched++;
        $display("[TB] FAIL reset_outputs: got busy,we,ga,gb,rva=%b, want 10000", {busy, ram_we, gnt_a, gnt_b, rvalid_a});
      end
      @(posedge clk); #1;
      preload_req = 1'b0;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      compared++;
      if ({busy, ram_we, gnt_a, gnt_b} !== 4'b1100 || ram_addr !== 4'(k) || ram_data !== CLEAR_VAL) begin
        mismatched++;
        $display("[TB] FAIL clear_step%0d: got busy,we,ga,gb=%b addr=%h data=%h, want 1100 addr=%h data=%h",
                 k, {busy, ram_we, gnt_a, gnt_b}, ram_addr, ram_data, 4'(k), CLEAR_VAL);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = CLEAR_VAL;
    for (int i = 0; i < 16; i++) begin
      req_a = 1'b1; we_a = 1'b0; addr_a = 4'(i);
      @(negedge clk);
      compared++;
      if ({busy, gnt_a, gnt_b} !== 3'b010) begin
        mismatched++;
        $display("[TB] FAIL clear_readback_gnt%0d: got busy,ga,gb=%b, want 010", i, {busy, gnt_a, gnt_b});
      end
      push_exp(1'b0, ref_mem[i]);
      @(posedge clk); #1;
    end
    drive_idle();
    @(negedge clk); #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL reset_drain: got %0d pending, want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; wdata_a = 4'b1111;
    @(negedge clk);
    compared++;
    if ({gnt_a, gnt_b, ram_we} !== 3'b101 || ram_addr !== 4'd3 || ram_data !== 4'b1111) begin
      mismatched++;
      $display("[TB] FAIL wr_write: got ga,gb,we=%b addr=%h data=%h, want 101 addr=3 data=f",
               {gnt_a, gnt_b, ram_we}, ram_addr, ram_data);
    end
    ref_mem[3] = 4'b1111;
    @(posedge clk); #1;
    drive_idle();
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd3;
    @(negedge clk);
    compared++;
    if ({gnt_a, gnt_b, ram_we} !== 3'b010 || ram_addr !== 4'd3) begin
      mismatched++;
      $display("[TB] FAIL wr_read: got ga,gb,we=%b addr=%h, want 010 addr=3", {gnt_a, gnt_b, ram_we}, ram_addr);
    end
    push_exp(1'b1, ref_mem[3]);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk); #1;
    compared++;
    if (rvalid_a !== 1'b0 || sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL wr_response: got rvalid_a=%0b pending=%0d, want 0 and 0", rvalid_a, sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic       want_a;
    logic [3:0] a_val;
    apply_reset(1);
    wait_clear();
    a_val = 4'd6;
    for (int i = 0; i < 6; i++) begin
      req_a = 1'b1; we_a = 1'b1; addr_a = 4'd9; wdata_a = a_val;
      req_b = 1'b1; we_b = 1'b0; addr_b = 4'd9;
      want_a = (i % 2 == 0);
      @(negedge clk);
      compared++;
      if (gnt_a !== want_a || gnt_b !== !want_a || ram_we !== want_a || busy !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL contention%0d: got ga=%0b gb=%0b we=%0b busy=%0b, want ga=%0b gb=%0b we=%0b busy=0",
                 i, gnt_a, gnt_b, ram_we, busy, want_a, !want_a, want_a);
      end
      if (want_a) begin
        ref_mem[9] = a_val;
      end else begin
        push_exp(1'b1, ref_mem[9]);
      end
      @(posedge clk); #1;
      if (want_a) a_val = a_val + 4'd3;
    end
    drive_idle();
    @(negedge clk); #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL contention_drain: got %0d pending, want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_request_during_clear();
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd5; wdata_a = 4'hC;
    @(negedge clk);
    compared++;
    if (gnt_a !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rdc_prewrite: got ga=%0b, want 1", gnt_a);
    end
    @(posedge clk); #1;
    apply_reset(2);
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd5;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      compared++;
      if ({busy, gnt_a, gnt_b} !== 3'b100) begin
        mismatched++;
        $display("[TB] FAIL rdc_hold%0d: got busy,ga,gb=%b, want 100", k, {busy, gnt_a, gnt_b});
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = CLEAR_VAL;
    @(negedge clk);
    compared++;
    if ({busy, gnt_a, gnt_b} !== 3'b001) begin
      mismatched++;
      $display("[TB] FAIL rdc_grant: got busy,ga,gb=%b, want 001", {busy, gnt_a, gnt_b});
    end
    push_exp(1'b1, ref_mem[5]);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk); #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL rdc_drain: got %0d pending, want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_clear();
    rst_n = 1'b0;
    drive_idle();
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    @(negedge clk);
    compared++;
    if (ram_addr !== 4'd7 || {busy, ram_we} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL midclr_pre: got addr=%h busy,we=%b, want addr=7 busy,we=11", ram_addr, {busy, ram_we});
    end
    #1;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({busy, ram_we} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL midclr_inreset: got busy,we=%b, want 10", {busy, ram_we});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      compared++;
      if ({busy, ram_we} !== 2'b11 || ram_addr !== 4'(k)) begin
        mismatched++;
        $display("[TB] FAIL midclr_step%0d: got busy,we=%b addr=%h, want 11 addr=%h", k, {busy, ram_we}, ram_addr, 4'(k));
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = CLEAR_VAL;
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd15;
    @(negedge clk);
    compared++;
    if ({busy, gnt_a} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL midclr_after: got busy,ga=%b, want 01", {busy, gnt_a});
    end
    push_exp(1'b0, ref_mem[15]);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk); #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL midclr_drain: got %0d pending, want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read_in_flight();
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd0;
    @(negedge clk);
    compared++;
    if (gnt_a !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL inflight_gnt: got ga=%0b, want 1", gnt_a);
    end
    @(posedge clk); #1;
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if (rvalid_a !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL inflight_rvalid_reset: got %0b, want 0", rvalid_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (rvalid_a !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL inflight_rvalid_after: got rvalid_a=%0b busy=%0b, want 0 and 1", rvalid_a, busy);
    end
    wait_clear();
  endtask

  task automatic test_lone_requester();
    for (int i = 0; i < 3; i++) begin
      req_a = 1'b1; we_a = 1'b1; addr_a = 4'(i); wdata_a = 4'(2 * i + 3);
      @(negedge clk);
      compared++;
      if ({gnt_a, gnt_b, ram_we} !== 3'b101 || ram_data !== 4'(2 * i + 3)) begin
        mismatched++;
        $display("[TB] FAIL lone_a_write%0d: got ga,gb,we=%b data=%h, want 101 data=%h",
                 i, {gnt_a, gnt_b, ram_we}, ram_data, 4'(2 * i + 3));
      end
      ref_mem[i] = 4'(2 * i + 3);
      @(posedge clk); #1;
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      req_b = 1'b1; we_b = 1'b0; addr_b = 4'(i);
      @(negedge clk);
      compared++;
      if ({gnt_a, gnt_b} !== 2'b01 || ram_addr !== 4'(i)) begin
        mismatched++;
        $display("[TB] FAIL lone_b_read%0d: got ga,gb=%b addr=%h, want 01 addr=%h", i, {gnt_a, gnt_b}, ram_addr, 4'(i));
      end
      push_exp(1'b1, ref_mem[i]);
      @(posedge clk); #1;
    end
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 4'd2;
    @(negedge clk);
    compared++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL lone_then_both: got ga,gb=%b, want 10", {gnt_a, gnt_b});
    end
    push_exp(1'b0, ref_mem[1]);
    @(posedge clk); #1;
    req_a = 1'b0;
    @(negedge clk);
    compared++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL lone_b_after: got ga,gb=%b, want 01", {gnt_a, gnt_b});
    end
    push_exp(1'b1, ref_mem[2]);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk); #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL lone_drain: got %0d pending, want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_request_during_clear();
    test_reset_mid_clear();
    test_read_in_flight();
    test_lone_requester();
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_ram_arbiter_16x4.md
# sync_ram_arbiter_16x4

Two-port round-robin access controller for the shared `sync_ram_16x4_file` memory (16 words × 4 bits, single port, synchronous write, one-cycle registered read). Two requesters, A and B, share the memory through it; the game sequencer and the display/playback logic are typical users.
- After reset it sequences an automatic clear pass, writing `CLEAR_VAL` to all 16 addresses before any request is served.
- It then grants at most one access per cycle with fair alternation.

## Interface
Parameters:
- `CLEAR_VAL`, 4'b0000, value written to every address during the clear pass
- `CLEAR_ON_RESET`, 1, 1 = run the clear pass after reset; 0 = enter SERVE directly

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous and active-low
- `req_a`, `req_b`  in  1  access request from A / B
- `we_a`, `we_b`  in  1  1 = write, 0 = read; qualified by req
- `addr_a`, `addr_b`  in  4  word address
- `wdata_a`, `wdata_b`  in  4  write data
- `gnt_a`, `gnt_b`  out  1  combinational grant; access is performed on the edge where req&gnt=1
- `rvalid_a`, `rvalid_b`  out  1  registered; rdata valid for the requester's read issued the previous cycle
- `rdata`  out  4  read data shared by both requesters (= `ram_q`)
- `busy`  out  1  high while the clear pass runs
- `ram_we`  out  1  RAM write enable
- `ram_addr`  out  4  RAM address
- `ram_data`  out  4  RAM write data
- `ram_q`  in  4  RAM read data, valid one cycle after the address is presented

## Operation
- States: CLEAR and SERVE. Registers: `state`, `clr_addr[3:0]`, `prio` (0 = A has priority, 1 = B), `rvalid_a`, `rvalid_b`.
- Reset (edge with `rst_n`=0):
  - `state` ← CLEAR if `CLEAR_ON_RESET`, else SERVE.
  - `clr_addr` ← 0, `prio` ← 0, `rvalid_a`/`rvalid_b` ← 0.
  - While `rst_n`=0, `ram_we`=0, `gnt_a`=`gnt_b`=0, and `busy`=`CLEAR_ON_RESET`.
- CLEAR:
  - Outputs: `ram_we`=1, `ram_addr`=`clr_addr`, `ram_data`=`CLEAR_VAL`, `busy`=1, no grants.
  - Each edge increments `clr_addr`. At the edge where `clr_addr`=15, `state` ← SERVE and `clr_addr` wraps to 0.
  - Requests asserted during CLEAR are held pending, not dropped.
- SERVE, grant rule (combinational):
  - Only `req_a` asserted → `gnt_a`. Only `req_b` asserted → `gnt_b`.
  - Both asserted → grant the side selected by `prio`. Neither → no grant.
- SERVE, RAM drive:
  - The granted side's `we`, `addr` and `wdata` drive `ram_we`, `ram_addr`, `ram_data`.
  - With no grant, `ram_we`=0, `ram_addr`=`addr_a`, `ram_data`=`wdata_a`.
- Priority update: on every granting edge, `prio` ← the non-granted side. A lone requester is therefore granted every cycle with no forced idle.
- Read valid: `rvalid_x` ← `req_x & gnt_x & ~we_x`. It is a one-cycle pulse per read, and `rdata`=`ram_q` in that cycle.
- Handshake: the requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt` high at a rising edge. It may deassert or change them in the following cycle. Back-to-back requests are allowed.
- Write data is committed on the granting edge. A read of the same address one cycle later returns the new value.
- Reset mid-operation:
  - Mid-CLEAR: restart at address 0 for a full 16 writes.
  - Mid-SERVE: pending `rvalid` is cleared and no response is delivered.

## Timing
- Clear pass: 16 cycles after the first edge with `rst_n`=1. The edges with `rst_n`=1 are numbered 1…16 and write addresses 0…15. `busy` falls after edge 16, and the first grant can occur in the cycle that follows.
- Grant: 0-cycle, combinational from `req` and `state`.
- Read latency: 1 cycle from the granting edge to `rvalid`/`rdata`.
- Write latency: 0 cycles, committed at the granting edge.
- Throughput: 1 access per cycle total. Under contention each side gets every other cycle.
- No combinational path from `ram_q` to any grant or RAM control output.

## Test plan
- Clear pass:
  - Stimulus: preload the RAM with nonzero values, pulse `rst_n` low for 2 cycles.
  - Response: `busy` high for exactly 16 cycles, `ram_addr` steps 0..15 with `ram_we`=1. Afterwards, A reads of all 16 addresses return 4'b0000 with `rvalid_a` one cycle after each grant.
- Write/read across ports:
  - Stimulus: A writes 4'b1111 at address 3, then B reads address 3 in the next cycle.
  - Response: `gnt_a`, then `gnt_b`, then `rvalid_b`=1 with `rdata`=4'b1111. `rvalid_a` stays 0.
- Contention:
  - Stimulus: `req_a` and `req_b` held high for 6 cycles after `busy` falls.
  - Response: grants go A,B,A,B,A,B (A first after reset), with exactly one grant per cycle.
- Request during clear:
  - Stimulus: `req_b` held (read, address 5) from the cycle after reset.
  - Response: no `gnt_b` while `busy`=1. `gnt_b` in the first SERVE cycle, `rvalid_b` one cycle later with 4'b0000.
- Reset mid-clear:
  - Stimulus: assert `rst_n`=0 when `clr_addr`=7, release after 1 cycle.
  - Response: clear restarts at address 0 and `busy` stays high for a further full 16 cycles.
- Reset with a read in flight:
  - Stimulus: assert reset on the cycle immediately after an A read grant.
  - Response: `rvalid_a` stays 0.
- Lone requester:
  - Stimulus: B alone issues 3 consecutive reads of addresses 0, 1, 2.
  - Response: `gnt_b` in 3 consecutive cycles and 3 consecutive `rvalid_b` pulses. When A then requests together with B, A is granted first (`prio`=A after the last B grant).
